// File: rtl/ifetch_pkg.sv
// Shared FSM type and default configuration for the instruction fetch stage.
// Defining IFETCH_STALL_CNT_EN adds a 16-bit decoder-stall counter output to instruction_fetch.
package ifetch_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    localparam int ADDR_W_DEF     = 8;
    localparam int INSTR_W_DEF    = 8;
    localparam int FIFO_DEPTH_DEF = 2;
    localparam int RESET_PC_DEF   = 0;
    localparam int STALL_CNT_W    = 16;

`ifdef IFETCH_STALL_CNT_EN
    localparam bit STALL_CNT_EN = 1'b1;
`else
    localparam bit STALL_CNT_EN = 1'b0;
`endif

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer holding {pc, instruction} pairs; flush empties it in one cycle.
// Head outputs read as zero while empty so the decoder never sees stale entries.
module fetch_fifo #(
    parameter  int DEPTH   = 2,
    parameter  int ADDR_W  = 8,
    parameter  int INSTR_W = 8,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [ADDR_W-1:0]  push_pc,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic               pop,
    input  logic               flush,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [INSTR_W-1:0] head_instr,
    output logic [CNT_W-1:0]   count,
    output logic               empty,
    output logic               full
);

    logic [ADDR_W+INSTR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    assign {head_pc, head_instr} = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !flush && (!full || pop);
        do_pop   = pop && !flush && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; empty gating hides its contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= {push_pc, push_instr};
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, single-outstanding req/ack reads, redirect/drain FSM, prefetch FIFO.
// Optional stall_cnt output is present only when IFETCH_STALL_CNT_EN is defined.
module instruction_fetch
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                INSTR_W    = INSTR_W_DEF,
    parameter int                FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEF)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc
`ifdef IFETCH_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    localparam int               CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              req_q, req_d;

    logic              ack_fire, pending_next;
    logic              fifo_push, fifo_pop, fifo_flush;
    logic              fifo_empty, fifo_full;
    logic [CNT_W-1:0]  fifo_count, count_next;

    assign ack_fire     = req_q && mem_ack;
    assign pending_next = req_q && !mem_ack;
    assign mem_req      = req_q;
    assign mem_addr     = addr_q;
    assign instr_valid  = !fifo_empty;

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .push_pc    (addr_q),
        .push_instr (mem_rdata),
        .pop        (fifo_pop),
        .flush      (fifo_flush),
        .head_pc    (instr_pc),
        .head_instr (instruction),
        .count      (fifo_count),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        target_d   = target_q;
        req_d      = req_q;
        fifo_flush = 1'b0;
        fifo_push  = 1'b0;
        fifo_pop   = instr_valid && instr_ready;
        count_next = fifo_count;
        if (redirect) begin
            // Redirect wins over everything: same-cycle pop and ack data are dropped.
            fifo_flush = 1'b1;
            fifo_pop   = 1'b0;
            target_d   = redirect_pc;
            if (pending_next) begin
                state_d = DRAIN;
            end else begin
                state_d = RUN;
                addr_d  = redirect_pc;
                req_d   = 1'b1;
            end
        end else if (state_q == DRAIN) begin
            if (ack_fire) begin
                state_d = RUN;
                addr_d  = target_q;
                req_d   = (fifo_count < DEPTH_C);
            end
        end else begin
            fifo_push  = ack_fire && (!fifo_full || fifo_pop);
            count_next = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
            if (ack_fire) addr_d = addr_q + 1'b1;
            // An unacked request must stay up; otherwise issue only if its data will fit.
            req_d = pending_next || (count_next < DEPTH_C);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            addr_q   <= RESET_PC;
            target_q <= RESET_PC;
            req_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            target_q <= target_d;
            req_q    <= req_d;
        end
    end

`ifdef IFETCH_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (instr_valid && !instr_ready && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
